stage_id: RTL and testbench

- Stage 2 (ID) of the 5-level MIPS pipeline.
- Decodes the IF/ID instruction and reads the register file, applying EX/MEM/WB forwarding.
- Detects load-use hazards and resolves branches/jumps.
- Owns the ID/EX pipeline register and drives the operand/control bundle consumed by stage_ex.

---
 rtl/pipeline_defs.sv | 72 +++++++
 rtl/stage_id_regfile.sv | 57 +++++
 rtl/stage_id.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_stage_id.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_defs.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_defs (package)
//  Purpose  : Shared constants for the MIPS pipeline: opcode and funct codes,
//             ALU operation encodings, the link register index, and the
//             ID/EX control bundle together with its bubble value.
//  Revision : 1.0 - initial release
// ============================================================================
package pipeline_defs;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] c_opc_rtype = 6'h00;
    localparam logic [5:0] c_opc_j     = 6'h02;
    localparam logic [5:0] c_opc_jal   = 6'h03;
    localparam logic [5:0] c_opc_beq   = 6'h04;
    localparam logic [5:0] c_opc_bne   = 6'h05;
    localparam logic [5:0] c_opc_addi  = 6'h08;
    localparam logic [5:0] c_opc_andi  = 6'h0C;
    localparam logic [5:0] c_opc_ori   = 6'h0D;
    localparam logic [5:0] c_opc_xori  = 6'h0E;
    localparam logic [5:0] c_opc_lui   = 6'h0F;
    localparam logic [5:0] c_opc_lw    = 6'h23;
    localparam logic [5:0] c_opc_sw    = 6'h2B;

    // R-type function codes (instr[5:0])
    localparam logic [5:0] c_fn_sll = 6'h00;
    localparam logic [5:0] c_fn_srl = 6'h02;
    localparam logic [5:0] c_fn_sra = 6'h03;
    localparam logic [5:0] c_fn_jr  = 6'h08;
    localparam logic [5:0] c_fn_mul = 6'h18;
    localparam logic [5:0] c_fn_div = 6'h1A;
    localparam logic [5:0] c_fn_add = 6'h20;
    localparam logic [5:0] c_fn_sub = 6'h22;
    localparam logic [5:0] c_fn_and = 6'h24;
    localparam logic [5:0] c_fn_or  = 6'h25;
    localparam logic [5:0] c_fn_xor = 6'h26;

    // ALU operations: op[1:0] selects the group, op[3:2] the member
    localparam logic [3:0] c_alu_add  = 4'b0000;
    localparam logic [3:0] c_alu_sub  = 4'b0100;
    localparam logic [3:0] c_alu_mul  = 4'b1000;
    localparam logic [3:0] c_alu_div  = 4'b1100;
    localparam logic [3:0] c_alu_and  = 4'b0001;
    localparam logic [3:0] c_alu_or   = 4'b0101;
    localparam logic [3:0] c_alu_xor  = 4'b1001;
    localparam logic [3:0] c_alu_lui  = 4'b1101;
    localparam logic [3:0] c_alu_sll  = 4'b0010;
    localparam logic [3:0] c_alu_srl  = 4'b1010;
    localparam logic [3:0] c_alu_sra  = 4'b1110;
    localparam logic [3:0] c_alu_pass = 4'b0011;

    localparam logic [4:0] REG_RA = 5'd31;

    typedef struct packed {
        logic [3:0] op;
        logic       aluimm;
        logic       shift;
        logic       jal;
        logic [4:0] rw;
        logic       wreg;
        logic       m2reg;
        logic       wmem;
    } ctrl_t;

    localparam ctrl_t c_ctrl_bubble = '0;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage : pipeline_defs
`default_nettype wire

// File: rtl/stage_id_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : stage_id_regfile
//  Purpose  : 32 x 32-bit register file, two read ports and one write port.
//             r0 always reads zero. A write in the same cycle as a read of
//             the same register returns the new value (write-through).
//  Ports    : clk, rst        - clock and synchronous active-high clear
//             i_ra_a, i_ra_b  - read addresses
//             o_rd_a, o_rd_b  - read data
//             i_we, i_wa, i_wd- write enable, address and data
//  Revision : 1.0 - initial release
// ============================================================================
module stage_id_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  i_ra_a,
    input  logic [4:0]  i_ra_b,
    output logic [31:0] o_rd_a,
    output logic [31:0] o_rd_b,
    input  logic        i_we,
    input  logic [4:0]  i_wa,
    input  logic [31:0] i_wd
);

    logic [31:0] r_mem [32];

    // Reset takes priority over a coincident write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we && (i_wa != 5'd0)) begin
            r_mem[i_wa] <= i_wd;
        end
    end

    always_comb begin
        o_rd_a = r_mem[i_ra_a];
        if (i_ra_a == 5'd0) begin
            o_rd_a = '0;
        end else if (i_we && (i_wa == i_ra_a)) begin
            o_rd_a = i_wd;
        end
    end

    always_comb begin
        o_rd_b = r_mem[i_ra_b];
        if (i_ra_b == 5'd0) begin
            o_rd_b = '0;
        end else if (i_we && (i_wa == i_ra_b)) begin
            o_rd_b = i_wd;
        end
    end

endmodule : stage_id_regfile
`default_nettype wire

// File: rtl/stage_id.sv
`default_nettype none
// ============================================================================
//  Module   : stage_id
//  Purpose  : Instruction-decode stage of the 5-stage MIPS pipeline. Decodes
//             the IF/ID instruction, reads the register file with EX/MEM/WB
//             forwarding, detects load-use hazards, resolves branches and
//             jumps, and owns the ID/EX pipeline register.
//  Ports    : clock, reset_0              - clock, sync active-high reset
//             instr_id, pc_id, valid_id   - IF/ID instruction, PC, valid
//             ans_fwd_ex                  - EX result for forwarding
//             mem_rw/data/we, wb_rw/data/we - MEM and WB write-back info
//             a_ex..wmem_ex               - ID/EX operand/control bundle
//             stall                       - hold PC and IF/ID
//             branch_taken, branch_target - IF redirect
//             illegal                     - unsupported instruction seen
//  Revision : 1.0 - initial release
// ============================================================================
module stage_id
    import pipeline_defs::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset_0,
    input  logic [31:0] instr_id,
    input  logic [31:0] pc_id,
    input  logic        valid_id,
    input  logic [31:0] ans_fwd_ex,
    input  logic [4:0]  mem_rw,
    input  logic [4:0]  wb_rw,
    input  logic [31:0] mem_data,
    input  logic [31:0] wb_data,
    input  logic        mem_we,
    input  logic        wb_we,
    output logic [31:0] a_ex,
    output logic [31:0] b_ex,
    output logic [31:0] imm_ex,
    output logic [31:0] pc_ex,
    output logic [3:0]  op_ex,
    output logic        aluimm_ex,
    output logic        shift_ex,
    output logic        jal_ex,
    output logic [4:0]  rw_ex,
    output logic        wreg_ex,
    output logic        m2reg_ex,
    output logic        wmem_ex,
    output logic        stall,
    output logic        branch_taken,
    output logic [31:0] branch_target,
    output logic        illegal
);

    logic [5:0]  w_opc;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [5:0]  w_funct;
    logic [31:0] w_rf_a;
    logic [31:0] w_rf_b;
    logic [31:0] w_fwd_a;
    logic [31:0] w_fwd_b;
    logic [31:0] w_imm;
    logic [31:0] w_pc4;
    ctrl_t       w_ctrl;
    logic        w_legal;
    logic        w_zext;
    logic        w_use_rs;
    logic        w_use_rt;
    logic        w_is_beq;
    logic        w_is_bne;
    logic        w_is_jump;
    logic        w_is_jr;
    logic        w_stall;
    logic        w_cond;
    logic        w_ex_fwd_ok;

    ctrl_t       r_ctrl;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_imm;
    logic [31:0] r_pc;
    logic        r_illegal;

    assign w_opc   = instr_id[31:26];
    assign w_rs    = instr_id[25:21];
    assign w_rt    = instr_id[20:16];
    assign w_rd    = instr_id[15:11];
    assign w_funct = instr_id[5:0];

    stage_id_regfile u_regfile (
        .clk    (clock),
        .rst    (reset_0),
        .i_ra_a (w_rs),
        .i_ra_b (w_rt),
        .o_rd_a (w_rf_a),
        .o_rd_b (w_rf_b),
        .i_we   (wb_we),
        .i_wa   (wb_rw),
        .i_wd   (wb_data)
    );

    // A load in EX has no result yet, so it must not forward; that case is
    // covered by the load-use stall instead.
    assign w_ex_fwd_ok = r_ctrl.wreg & ~r_ctrl.m2reg;

    function automatic logic [31:0] fwd_sel(
        input logic [4:0]  src,
        input logic [31:0] rf_val,
        input logic        ex_ok,
        input logic [4:0]  ex_rw,
        input logic [31:0] ex_val,
        input logic        m_we,
        input logic [4:0]  m_rw,
        input logic [31:0] m_val,
        input logic        b_we,
        input logic [4:0]  b_rw,
        input logic [31:0] b_val
    );
        if (src == 5'd0)                   return 32'd0;
        else if (ex_ok && (ex_rw == src))  return ex_val;
        else if (m_we && (m_rw == src))    return m_val;
        else if (b_we && (b_rw == src))    return b_val;
        else                               return rf_val;
    endfunction

    always_comb begin
        w_fwd_a = fwd_sel(w_rs, w_rf_a, w_ex_fwd_ok, r_ctrl.rw, ans_fwd_ex,
                          mem_we, mem_rw, mem_data, wb_we, wb_rw, wb_data);
        w_fwd_b = fwd_sel(w_rt, w_rf_b, w_ex_fwd_ok, r_ctrl.rw, ans_fwd_ex,
                          mem_we, mem_rw, mem_data, wb_we, wb_rw, wb_data);
    end

    // Instruction decode
    always_comb begin
        w_ctrl        = c_ctrl_bubble;
        w_ctrl.op     = c_alu_add;
        w_ctrl.aluimm = 1'b1;
        w_ctrl.shift  = 1'b1;
        w_ctrl.jal    = 1'b1;
        w_legal       = 1'b1;
        w_zext        = 1'b0;
        w_use_rs      = 1'b0;
        w_use_rt      = 1'b0;
        w_is_beq      = 1'b0;
        w_is_bne      = 1'b0;
        w_is_jump     = 1'b0;
        w_is_jr       = 1'b0;

        case (w_opc)
            c_opc_rtype: begin
                w_use_rs    = 1'b1;
                w_use_rt    = 1'b1;
                w_ctrl.rw   = w_rd;
                w_ctrl.wreg = 1'b1;
                case (w_funct)
                    c_fn_add: w_ctrl.op = c_alu_add;
                    c_fn_sub: w_ctrl.op = c_alu_sub;
                    c_fn_mul: w_ctrl.op = c_alu_mul;
                    c_fn_div: w_ctrl.op = c_alu_div;
                    c_fn_and: w_ctrl.op = c_alu_and;
                    c_fn_or:  w_ctrl.op = c_alu_or;
                    c_fn_xor: w_ctrl.op = c_alu_xor;
                    c_fn_sll, c_fn_srl, c_fn_sra: begin
                        // Shift amount comes from imm_ex; rs is not read.
                        w_use_rs     = 1'b0;
                        w_ctrl.shift = 1'b0;
                        w_ctrl.op    = (w_funct == c_fn_sll) ? c_alu_sll :
                                       (w_funct == c_fn_srl) ? c_alu_srl :
                                                               c_alu_sra;
                    end
                    c_fn_jr: begin
                        w_use_rt    = 1'b0;
                        w_ctrl.rw   = 5'd0;
                        w_ctrl.wreg = 1'b0;
                        w_is_jr     = 1'b1;
                    end
                    default: w_legal = 1'b0;
                endcase
            end
            c_opc_addi: begin
                w_use_rs      = 1'b1;
                w_ctrl.aluimm = 1'b0;
                w_ctrl.rw     = w_rt;
                w_ctrl.wreg   = 1'b1;
            end
            c_opc_andi, c_opc_ori, c_opc_xori: begin
                w_use_rs      = 1'b1;
                w_zext        = 1'b1;
                w_ctrl.aluimm = 1'b0;
                w_ctrl.rw     = w_rt;
                w_ctrl.wreg   = 1'b1;
                w_ctrl.op     = (w_opc == c_opc_andi) ? c_alu_and :
                                (w_opc == c_opc_ori)  ? c_alu_or  :
                                                        c_alu_xor;
            end
            c_opc_lui: begin
                w_zext        = 1'b1;
                w_ctrl.op     = c_alu_lui;
                w_ctrl.aluimm = 1'b0;
                w_ctrl.rw     = w_rt;
                w_ctrl.wreg   = 1'b1;
            end
            c_opc_lw: begin
                w_use_rs      = 1'b1;
                w_ctrl.aluimm = 1'b0;
                w_ctrl.rw     = w_rt;
                w_ctrl.wreg   = 1'b1;
                w_ctrl.m2reg  = 1'b1;
            end
            c_opc_sw: begin
                w_use_rs      = 1'b1;
                w_use_rt      = 1'b1;
                w_ctrl.aluimm = 1'b0;
                w_ctrl.wmem   = 1'b1;
            end
            c_opc_beq, c_opc_bne: begin
                w_use_rs = 1'b1;
                w_use_rt = 1'b1;
                w_is_beq = (w_opc == c_opc_beq);
                w_is_bne = (w_opc == c_opc_bne);
            end
            c_opc_j: begin
                w_is_jump = 1'b1;
            end
            c_opc_jal: begin
                w_is_jump   = 1'b1;
                w_ctrl.op   = c_alu_pass;
                w_ctrl.jal  = 1'b0;
                w_ctrl.rw   = REG_RA;
                w_ctrl.wreg = 1'b1;
            end
            default: w_legal = 1'b0;
        endcase

        // r0 is never a real destination.
        if (w_ctrl.rw == 5'd0) begin
            w_ctrl.wreg = 1'b0;
        end
    end

    assign w_imm = w_zext ? {16'd0, instr_id[15:0]} : sext16(instr_id[15:0]);
    assign w_pc4 = pc_id + 32'd4;

    assign w_stall = valid_id & w_legal & r_ctrl.m2reg & (r_ctrl.rw != 5'd0) &
                     ((w_use_rs & (w_rs == r_ctrl.rw)) |
                      (w_use_rt & (w_rt == r_ctrl.rw)));

    assign w_cond = (w_is_beq & (w_fwd_a == w_fwd_b)) |
                    (w_is_bne & (w_fwd_a != w_fwd_b)) |
                    w_is_jump | w_is_jr;

    always_comb begin
        branch_target = w_pc4 + {w_imm[29:0], 2'b00};
        if (w_is_jump) begin
            branch_target = {w_pc4[31:28], instr_id[25:0], 2'b00};
        end else if (w_is_jr) begin
            branch_target = w_fwd_a;
        end
    end

    assign stall        = w_stall;
    assign branch_taken = valid_id & w_legal & ~w_stall & w_cond;

    // ID/EX pipeline register
    always_ff @(posedge clock) begin
        if (reset_0) begin
            r_ctrl    <= c_ctrl_bubble;
            r_a       <= '0;
            r_b       <= '0;
            r_imm     <= '0;
            r_pc      <= RESET_PC;
            r_illegal <= 1'b0;
        end else begin
            r_a       <= w_fwd_a;
            r_b       <= w_fwd_b;
            r_imm     <= w_imm;
            r_pc      <= pc_id;
            r_ctrl    <= (valid_id && w_legal && !w_stall) ? w_ctrl : c_ctrl_bubble;
            r_illegal <= valid_id & ~w_legal;
        end
    end

    assign a_ex      = r_a;
    assign b_ex      = r_b;
    assign imm_ex    = r_imm;
    assign pc_ex     = r_pc;
    assign op_ex     = r_ctrl.op;
    assign aluimm_ex = r_ctrl.aluimm;
    assign shift_ex  = r_ctrl.shift;
    assign jal_ex    = r_ctrl.jal;
    assign rw_ex     = r_ctrl.rw;
    assign wreg_ex   = r_ctrl.wreg;
    assign m2reg_ex  = r_ctrl.m2reg;
    assign wmem_ex   = r_ctrl.wmem;
    assign illegal   = r_illegal;

endmodule : stage_id
`default_nettype wire

// File: tb/tb_stage_id.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stage_id
//  Purpose  : Self-checking bench for stage_id. A table of directed vectors
//             is applied one per clock; combinational outputs are checked
//             before the edge and ID/EX outputs just after it. A mid-run
//             reset sequence is checked by hand at the end.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_stage_id;

    localparam logic [31:0] c_reset_pc = 32'hBFC0_0000;
    localparam int          c_nvec     = 18;

    logic        clock = 1'b0;
    logic        reset_0;
    logic [31:0] instr_id, pc_id, ans_fwd_ex, mem_data, wb_data;
    logic        valid_id, mem_we, wb_we;
    logic [4:0]  mem_rw, wb_rw;
    logic [31:0] a_ex, b_ex, imm_ex, pc_ex, branch_target;
    logic [3:0]  op_ex;
    logic        aluimm_ex, shift_ex, jal_ex, wreg_ex, m2reg_ex, wmem_ex;
    logic        stall, branch_taken, illegal;
    logic [4:0]  rw_ex;

    int checks   = 0;
    int failures = 0;

    stage_id #(.RESET_PC(c_reset_pc)) dut (
        .clock(clock), .reset_0(reset_0), .instr_id(instr_id), .pc_id(pc_id),
        .valid_id(valid_id), .ans_fwd_ex(ans_fwd_ex), .mem_rw(mem_rw),
        .wb_rw(wb_rw), .mem_data(mem_data), .wb_data(wb_data),
        .mem_we(mem_we), .wb_we(wb_we), .a_ex(a_ex), .b_ex(b_ex),
        .imm_ex(imm_ex), .pc_ex(pc_ex), .op_ex(op_ex), .aluimm_ex(aluimm_ex),
        .shift_ex(shift_ex), .jal_ex(jal_ex), .rw_ex(rw_ex),
        .wreg_ex(wreg_ex), .m2reg_ex(m2reg_ex), .wmem_ex(wmem_ex),
        .stall(stall), .branch_taken(branch_taken),
        .branch_target(branch_target), .illegal(illegal)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        valid;
        logic [31:0] ans;
        logic [4:0]  mrw;
        logic [31:0] mdata;
        logic        mwe;
        logic [4:0]  wrw;
        logic [31:0] wdata;
        logic        wwe;
        logic        e_stall;
        logic        e_bt;
        logic [31:0] e_tgt;
        logic [15:0] e_ctrl;
        logic        chk_data;
        logic [31:0] e_a;
        logic [31:0] e_b;
        logic [31:0] e_imm;
    } vec_t;

    vec_t tv [c_nvec];

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] t);
        return {op, t};
    endfunction

    // {op, aluimm, shift, jal, rw, wreg, m2reg, wmem, illegal}
    function automatic logic [15:0] mkc(input logic [3:0] op, input logic al,
                                        input logic sh, input logic jl,
                                        input logic [4:0] rw, input logic wr,
                                        input logic m2, input logic wm,
                                        input logic il);
        return {op, al, sh, jl, rw, wr, m2, wm, il};
    endfunction

    task automatic set_in(input int i, input logic [31:0] instr, input logic [31:0] pc,
                          input logic valid, input logic [31:0] ans,
                          input logic [4:0] mrw, input logic [31:0] mdata, input logic mwe,
                          input logic [4:0] wrw, input logic [31:0] wdata, input logic wwe);
        tv[i].instr = instr; tv[i].pc = pc; tv[i].valid = valid; tv[i].ans = ans;
        tv[i].mrw = mrw; tv[i].mdata = mdata; tv[i].mwe = mwe;
        tv[i].wrw = wrw; tv[i].wdata = wdata; tv[i].wwe = wwe;
    endtask

    task automatic set_ex(input int i, input logic st, input logic bt, input logic [31:0] tgt,
                          input logic [15:0] ctrl, input logic cd,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm);
        tv[i].e_stall = st; tv[i].e_bt = bt; tv[i].e_tgt = tgt; tv[i].e_ctrl = ctrl;
        tv[i].chk_data = cd; tv[i].e_a = a; tv[i].e_b = b; tv[i].e_imm = imm;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] act_ctrl();
        return {op_ex, aluimm_ex, shift_ex, jal_ex, rw_ex, wreg_ex, m2reg_ex, wmem_ex, illegal};
    endfunction

    task automatic chk_reset_state(input string tag);
        chk({tag, " ctrl"}, {16'd0, act_ctrl()}, 32'd0);
        chk({tag, " a_ex"}, a_ex, 32'd0);
        chk({tag, " b_ex"}, b_ex, 32'd0);
        chk({tag, " imm_ex"}, imm_ex, 32'd0);
        chk({tag, " pc_ex"}, pc_ex, c_reset_pc);
    endtask

    task automatic apply(input int i);
        instr_id = tv[i].instr; pc_id = tv[i].pc; valid_id = tv[i].valid;
        ans_fwd_ex = tv[i].ans;
        mem_rw = tv[i].mrw; mem_data = tv[i].mdata; mem_we = tv[i].mwe;
        wb_rw = tv[i].wrw; wb_data = tv[i].wdata; wb_we = tv[i].wwe;
        #2;
        chk($sformatf("v%0d stall", i), {31'd0, stall}, {31'd0, tv[i].e_stall});
        chk($sformatf("v%0d branch_taken", i), {31'd0, branch_taken}, {31'd0, tv[i].e_bt});
        if (tv[i].e_bt)
            chk($sformatf("v%0d branch_target", i), branch_target, tv[i].e_tgt);
        @(posedge clock); #1;
        chk($sformatf("v%0d ctrl", i), {16'd0, act_ctrl()}, {16'd0, tv[i].e_ctrl});
        if (tv[i].chk_data) begin
            chk($sformatf("v%0d a_ex", i), a_ex, tv[i].e_a);
            chk($sformatf("v%0d b_ex", i), b_ex, tv[i].e_b);
            chk($sformatf("v%0d imm_ex", i), imm_ex, tv[i].e_imm);
            chk($sformatf("v%0d pc_ex", i), pc_ex, tv[i].pc);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] bub;
        bub = mkc(4'd0, 0, 0, 0, 5'd0, 0, 0, 0, 0);

        // addi r1,r0,5 ; WB writes r7=0x70
        set_in(0, enc_i(6'h08, 0, 1, 16'd5), 32'h10, 1, 32'h0, 0, 0, 0, 7, 32'h70, 1);
        set_ex(0, 0, 0, 0, mkc(4'b0000, 0, 1, 1, 1, 1, 0, 0, 0), 1, 0, 0, 5);
        // add r2,r1,r1 : EX forward beats MEM
        set_in(1, enc_r(1, 1, 2, 0, 6'h20), 32'h14, 1, 32'h5, 1, 32'h99, 1, 0, 0, 0);
        set_ex(1, 0, 0, 0, mkc(4'b0000, 1, 1, 1, 2, 1, 0, 0, 0), 1, 5, 5, 32'h1020);
        // lw r4,0(r1) : MEM beats WB ; WB writes r1=0x77
        set_in(2, enc_i(6'h23, 1, 4, 16'd0), 32'h18, 1, 32'hEE, 1, 32'h5, 1, 1, 32'h77, 1);
        set_ex(2, 0, 0, 0, mkc(4'b0000, 0, 1, 1, 4, 1, 1, 0, 0), 1, 5, 0, 0);
        // sub r5,r4,r1 : load-use stall, bubble
        set_in(3, enc_r(4, 1, 5, 0, 6'h22), 32'h1C, 1, 32'hEE, 2, 32'd10, 1, 0, 0, 0);
        set_ex(3, 1, 0, 0, bub, 0, 0, 0, 0);
        // sub reissued, rs from MEM ; WB writes r2=10
        set_in(4, enc_r(4, 1, 5, 0, 6'h22), 32'h1C, 1, 32'hEE, 4, 32'h44, 1, 2, 32'd10, 1);
        set_ex(4, 0, 0, 0, mkc(4'b0100, 1, 1, 1, 5, 1, 0, 0, 0), 1, 32'h44, 32'h77, 32'h2822);
        // beq r1,r1,+3 at 0x100
        set_in(5, enc_i(6'h04, 1, 1, 16'd3), 32'h100, 1, 32'hEE, 0, 0, 0, 0, 0, 0);
        set_ex(5, 0, 1, 32'h110, mkc(4'b0000, 1, 1, 1, 0, 0, 0, 0, 0), 1, 32'h77, 32'h77, 3);
        // lw r8,0(r0)
        set_in(6, enc_i(6'h23, 0, 8, 16'd0), 32'h104, 1, 0, 0, 0, 0, 0, 0, 0);
        set_ex(6, 0, 0, 0, mkc(4'b0000, 0, 1, 1, 8, 1, 1, 0, 0), 1, 0, 0, 0);
        // beq r8,r8,+3 under load-use stall : branch suppressed
        set_in(7, enc_i(6'h04, 8, 8, 16'd3), 32'h108, 1, 0, 0, 0, 0, 0, 0, 0);
        set_ex(7, 1, 0, 0, bub, 0, 0, 0, 0);
        // same beq after stall, r8 from MEM
        set_in(8, enc_i(6'h04, 8, 8, 16'd3), 32'h108, 1, 32'hEE, 8, 32'h123, 1, 0, 0, 0);
        set_ex(8, 0, 1, 32'h118, mkc(4'b0000, 1, 1, 1, 0, 0, 0, 0, 0), 1, 32'h123, 32'h123, 3);
        // jal 0x40 at 0x200
        set_in(9, enc_j(6'h03, 26'h40), 32'h200, 1, 0, 0, 0, 0, 0, 0, 0);
        set_ex(9, 0, 1, 32'h100, mkc(4'b0011, 1, 1, 0, 31, 1, 0, 0, 0), 1, 0, 0, 32'h40);
        // sll r6,r7,3 with simultaneous WB write of r7
        set_in(10, enc_r(0, 7, 6, 3, 6'h00), 32'h204, 1, 32'hEE, 0, 0, 0, 7, 32'h7777, 1);
        set_ex(10, 0, 0, 0, mkc(4'b0010, 1, 0, 1, 6, 1, 0, 0, 0), 1, 0, 32'h7777, 32'h30C0);
        // opcode 0x3F : illegal
        set_in(11, 32'hFC00_0000, 32'h208, 1, 0, 0, 0, 0, 0, 0, 0);
        set_ex(11, 0, 0, 0, mkc(4'd0, 0, 0, 0, 0, 0, 0, 0, 1), 0, 0, 0, 0);
        // invalid slot holding a jump : bubble, no redirect, illegal drops
        set_in(12, enc_j(6'h02, 26'h123), 32'h20C, 0, 0, 0, 0, 0, 0, 0, 0);
        set_ex(12, 0, 0, 0, bub, 0, 0, 0, 0);
        // sw r7,8(r2) from register file
        set_in(13, enc_i(6'h2B, 2, 7, 16'd8), 32'h210, 1, 0, 0, 0, 0, 0, 0, 0);
        set_ex(13, 0, 0, 0, mkc(4'b0000, 0, 1, 1, 0, 0, 0, 1, 0), 1, 32'd10, 32'h7777, 8);
        // jr r2
        set_in(14, enc_r(2, 0, 0, 0, 6'h08), 32'h300, 1, 0, 0, 0, 0, 0, 0, 0);
        set_ex(14, 0, 1, 32'h0000_000A, mkc(4'b0000, 1, 1, 1, 0, 0, 0, 0, 0), 1, 32'd10, 0, 8);
        // xori r9,r1,0x8001 : zero-extended
        set_in(15, enc_i(6'h0E, 1, 9, 16'h8001), 32'h304, 1, 0, 0, 0, 0, 0, 0, 0);
        set_ex(15, 0, 0, 0, mkc(4'b1001, 0, 1, 1, 9, 1, 0, 0, 0), 1, 32'h77, 0, 32'h8001);
        // or r11,r0,r9 : r9 from EX, r0 ignores MEM write to r0
        set_in(16, enc_r(0, 9, 11, 0, 6'h25), 32'h308, 1, 32'hABCD, 0, 32'hBAD, 1, 0, 0, 0);
        set_ex(16, 0, 0, 0, mkc(4'b0101, 1, 1, 1, 11, 1, 0, 0, 0), 1, 0, 32'hABCD, 32'h5825);
        // add r0,r1,r1 : write to r0 suppressed
        set_in(17, enc_r(1, 1, 0, 0, 6'h20), 32'h30C, 1, 32'hEE, 0, 0, 0, 0, 0, 0);
        set_ex(17, 0, 0, 0, mkc(4'b0000, 1, 1, 1, 0, 0, 0, 0, 0), 1, 32'h77, 32'h77, 32'h20);

        reset_0 = 1'b1; instr_id = '0; pc_id = '0; valid_id = 1'b0; ans_fwd_ex = '0;
        mem_rw = '0; mem_data = '0; mem_we = 1'b0; wb_rw = '0; wb_data = '0; wb_we = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk_reset_state("reset");
        reset_0 = 1'b0;

        for (int i = 0; i < c_nvec; i++) begin
            apply(i);
        end

        // Mid-run reset with a coincident WB write to r3
        reset_0 = 1'b1; valid_id = 1'b1; instr_id = enc_i(6'h08, 0, 1, 16'd9); pc_id = 32'h3F0;
        mem_we = 1'b0; wb_we = 1'b1; wb_rw = 5'd3; wb_data = 32'h33;
        @(posedge clock); #1;
        chk_reset_state("midreset");
        reset_0 = 1'b0; wb_we = 1'b0;
        instr_id = enc_r(3, 1, 8, 0, 6'h20); pc_id = 32'h400; ans_fwd_ex = 32'hEE;
        #2;
        chk("post-reset stall", {31'd0, stall}, 32'd0);
        @(posedge clock); #1;
        chk("post-reset r3", a_ex, 32'd0);
        chk("post-reset r1", b_ex, 32'd0);
        chk("post-reset ctrl", {16'd0, act_ctrl()}, {16'd0, mkc(4'b0000, 1, 1, 1, 8, 1, 0, 0, 0)});
        chk("post-reset pc_ex", pc_ex, 32'h400);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_stage_id
`default_nettype wire
